// File: rtl/ekf_mem_arbiter.sv
// Round-robin arbiter for the EKF state/matrix RAM port with per-requester lock,
// idle-timeout lock release and in-order 2-cycle read-response routing.
module ekf_mem_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int ADDR_WIDTH   = 10,
    parameter int DATA_WIDTH   = 32,
    parameter int LOCK_TIMEOUT = 16,
    localparam int PTR_W       = $clog2(NUM_REQ),
    localparam int CNT_W       = $clog2(LOCK_TIMEOUT) + 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ-1:0]            req_we,
    input  logic [NUM_REQ-1:0]            req_lock,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
    output logic [NUM_REQ-1:0]            rsp_valid,
    output logic [DATA_WIDTH-1:0]         rsp_data,
    output logic [ADDR_WIDTH-1:0]         mem_addr,
    output logic [DATA_WIDTH-1:0]         mem_wdata,
    output logic                          mem_we,
    input  logic [DATA_WIDTH-1:0]         mem_q,
    output logic [PTR_W-1:0]              lock_owner,
    output logic                          locked,
    output logic                          lock_timeout
);

    typedef enum logic {S_IDLE, S_LOCKED} state_t;

    state_t                state_reg;
    logic [PTR_W-1:0]      ptr_reg;
    logic [CNT_W-1:0]      idle_cnt_reg;
    logic                  rd_valid_reg;
    logic [PTR_W-1:0]      rd_id_reg;

    logic [ADDR_WIDTH-1:0] addr_arr  [NUM_REQ];
    logic [DATA_WIDTH-1:0] wdata_arr [NUM_REQ];

    logic                  grant_any;
    logic [PTR_W-1:0]      grant_idx;
    logic                  sel_we;
    logic                  sel_lock;

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign addr_arr[gi]  = req_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
            assign wdata_arr[gi] = req_wdata[gi*DATA_WIDTH +: DATA_WIDTH];
        end
    endgenerate

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] i);
        return (int'(i) == NUM_REQ - 1) ? '0 : i + PTR_W'(1);
    endfunction

    // Locked: only the owner may be served. Idle: first valid at or after ptr, wrapping.
    always_comb begin
        int               idx;
        logic [PTR_W-1:0] cand;
        grant_any = 1'b0;
        grant_idx = '0;
        req_ready = '0;
        idx       = 0;
        cand      = '0;
        if (state_reg == S_LOCKED) begin
            if (req_valid[lock_owner]) begin
                grant_any = 1'b1;
                grant_idx = lock_owner;
            end
        end else begin
            for (int k = 0; k < NUM_REQ; k++) begin
                idx = int'(ptr_reg) + k;
                if (idx >= NUM_REQ) idx = idx - NUM_REQ;
                cand = PTR_W'(idx);
                if (!grant_any && req_valid[cand]) begin
                    grant_any = 1'b1;
                    grant_idx = cand;
                end
            end
        end
        if (grant_any) req_ready[grant_idx] = 1'b1;
    end

    assign sel_we   = req_we[grant_idx];
    assign sel_lock = req_lock[grant_idx];

    // RAM q is already registered, so the response data is passed through, gated by the strobe.
    assign rsp_data = (|rsp_valid) ? mem_q : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= S_IDLE;
            ptr_reg      <= '0;
            idle_cnt_reg <= '0;
            rd_valid_reg <= 1'b0;
            rd_id_reg    <= '0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            mem_we       <= 1'b0;
            rsp_valid    <= '0;
            lock_owner   <= '0;
            locked       <= 1'b0;
            lock_timeout <= 1'b0;
        end else begin
            lock_timeout <= 1'b0;
            mem_we       <= grant_any & sel_we;
            rd_valid_reg <= grant_any & ~sel_we;
            rd_id_reg    <= grant_idx;
            rsp_valid    <= rd_valid_reg ? (NUM_REQ'(1) << rd_id_reg) : '0;
            if (grant_any) begin
                mem_addr  <= addr_arr[grant_idx];
                mem_wdata <= wdata_arr[grant_idx];
            end

            case (state_reg)
                S_IDLE: begin
                    if (grant_any) begin
                        ptr_reg <= next_ptr(grant_idx);
                        if (sel_lock) begin
                            state_reg    <= S_LOCKED;
                            lock_owner   <= grant_idx;
                            locked       <= 1'b1;
                            idle_cnt_reg <= '0;
                        end
                    end
                end
                S_LOCKED: begin
                    if (grant_any) begin
                        if (sel_lock) begin
                            idle_cnt_reg <= '0;
                        end else begin
                            state_reg <= S_IDLE;
                            locked    <= 1'b0;
                            ptr_reg   <= next_ptr(lock_owner);
                        end
                    end else if (idle_cnt_reg == CNT_W'(LOCK_TIMEOUT - 2)) begin
                        // Release decided here so the pulse lands LOCK_TIMEOUT cycles after the last beat.
                        state_reg    <= S_IDLE;
                        locked       <= 1'b0;
                        lock_timeout <= 1'b1;
                        ptr_reg      <= next_ptr(lock_owner);
                    end else if (idle_cnt_reg != '1) begin
                        idle_cnt_reg <= idle_cnt_reg + 1'b1;
                    end
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ekf_mem_arbiter.sv
// Directed bench for ekf_mem_arbiter: read latency, round-robin order, lock burst,
// lock timeout, write-then-read and reset in flight, with a read-first RAM model.
module tb_ekf_mem_arbiter;

    localparam int NR = 4;
    localparam int AW = 8;
    localparam int DW = 32;
    localparam int LT = 16;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [NR-1:0]    req_valid, req_ready, req_we, req_lock;
    logic [NR*AW-1:0] req_addr;
    logic [NR*DW-1:0] req_wdata;
    logic [NR-1:0]    rsp_valid;
    logic [DW-1:0]    rsp_data;
    logic [AW-1:0]    mem_addr;
    logic [DW-1:0]    mem_wdata;
    logic             mem_we;
    logic [DW-1:0]    mem_q;
    logic [1:0]       lock_owner;
    logic             locked;
    logic             lock_timeout;

    int checks   = 0;
    int failures = 0;

    ekf_mem_arbiter #(
        .NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LOCK_TIMEOUT(LT)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_lock(req_lock),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_q(mem_q),
        .lock_owner(lock_owner), .locked(locked), .lock_timeout(lock_timeout)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] ram_default(input logic [AW-1:0] a);
        return (a == 8'h05) ? 32'h0000_1000 : (32'hA000_0000 | {24'h0, a});
    endfunction

    // Read-first RAM with registered output; unwritten words return ram_default.
    logic [DW-1:0]     ram [256];
    logic [255:0]      wr_mask;
    always @(posedge clk) begin
        if (!rst_n) begin
            wr_mask <= '0;
        end else if (mem_we) begin
            ram[mem_addr]     <= mem_wdata;
            wr_mask[mem_addr] <= 1'b1;
        end
        mem_q <= wr_mask[mem_addr] ? ram[mem_addr] : ram_default(mem_addr);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end else begin
            $display("check %s got=%0h ok", tag, got);
        end
    endtask

    task automatic clear_reqs();
        req_valid = '0;
        req_we    = '0;
        req_lock  = '0;
        req_addr  = '0;
        req_wdata = '0;
    endtask

    task automatic set_req(input int i, input logic v, input logic we, input logic lk,
                           input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_valid[i]          = v;
        req_we[i]             = we;
        req_lock[i]           = lk;
        req_addr[i*AW +: AW]  = a;
        req_wdata[i*DW +: DW] = d;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clear_reqs();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
    endtask

    logic [3:0] exp4;
    int         r;

    initial begin
        rst_n = 1'b0;
        clear_reqs();
        @(negedge clk);
        check("reset_ctrl", {req_ready, rsp_valid, mem_we, locked, lock_timeout, lock_owner, mem_addr}, '0);
        check("reset_data", {mem_wdata, rsp_data}, '0);

        // Single read: req 1, addr 0x05
        do_reset();
        next_cycle(); set_req(1, 1'b1, 1'b0, 1'b0, 8'h05, '0);
        @(negedge clk); check("t1_ready", req_ready, 4'b0010);
        next_cycle(); clear_reqs();
        @(negedge clk);
        check("t1_mem_addr", mem_addr, 8'h05);
        check("t1_mem_we", mem_we, 1'b0);
        check("t1_rsp_early", rsp_valid, 4'b0000);
        next_cycle(); @(negedge clk);
        check("t1_rsp_valid", rsp_valid, 4'b0010);
        check("t1_rsp_data", rsp_data, 32'h0000_1000);
        next_cycle(); @(negedge clk);
        check("t1_rsp_done", rsp_valid, 4'b0000);

        // Round-robin: all four read for 8 cycles
        do_reset();
        for (int c = 0; c < 10; c++) begin
            next_cycle();
            if (c < 8) begin
                for (int i = 0; i < NR; i++) set_req(i, 1'b1, 1'b0, 1'b0, 8'(8'h20 + i), '0);
            end else begin
                clear_reqs();
            end
            @(negedge clk);
            exp4 = (c < 8) ? (4'b0001 << (c % 4)) : 4'b0000;
            check($sformatf("t2_ready_c%0d", c), req_ready, exp4);
            if (c >= 2) begin
                r = (c - 2) % 4;
                check($sformatf("t2_rsp_valid_c%0d", c), rsp_valid, 4'b0001 << r);
                check($sformatf("t2_rsp_data_c%0d", c), rsp_data, ram_default(8'(8'h20 + r)));
            end else begin
                check($sformatf("t2_rsp_none_c%0d", c), rsp_valid, 4'b0000);
            end
        end

        // Lock burst: move ptr to 2, then req 2 writes 4 locked beats while 0 and 3 wait
        do_reset();
        next_cycle(); set_req(1, 1'b1, 1'b0, 1'b0, 8'h01, '0);
        @(negedge clk); check("t3_pre_ready", req_ready, 4'b0010);
        for (int b = 0; b < 6; b++) begin
            next_cycle();
            clear_reqs();
            if (b < 5) set_req(0, 1'b1, 1'b0, 1'b0, 8'h40, '0);
            if (b < 5) set_req(3, 1'b1, 1'b0, 1'b0, 8'h43, '0);
            if (b == 5) set_req(0, 1'b1, 1'b0, 1'b0, 8'h40, '0);
            if (b < 4) set_req(2, 1'b1, 1'b1, (b < 3), 8'(8'h30 + b), 32'hB0 + 32'(b));
            @(negedge clk);
            exp4 = (b < 4) ? 4'b0100 : ((b == 4) ? 4'b1000 : 4'b0001);
            check($sformatf("t3_ready_b%0d", b), req_ready, exp4);
            check($sformatf("t3_locked_b%0d", b), locked, (b >= 1 && b <= 3));
            if (b >= 1 && b <= 4)
                check($sformatf("t3_wr_b%0d", b), {mem_we, mem_addr, mem_wdata},
                      {1'b1, 8'(8'h30 + b - 1), 32'hB0 + 32'(b - 1)});
            if (b == 1) check("t3_owner", lock_owner, 2'd2);
        end

        // Lock timeout: req 1 locks then goes silent, req 0 waits
        do_reset();
        next_cycle(); clear_reqs(); set_req(1, 1'b1, 1'b0, 1'b1, 8'h50, '0);
        @(negedge clk); check("t4_lock_ready", req_ready, 4'b0010);
        next_cycle(); clear_reqs(); set_req(0, 1'b1, 1'b0, 1'b0, 8'h51, '0);
        @(negedge clk);
        check("t4_owner", lock_owner, 2'd1);
        check("t4_hold_k1", {lock_timeout, locked, req_ready}, 6'b010000);
        for (int k = 2; k < 16; k++) begin
            next_cycle(); @(negedge clk);
            check($sformatf("t4_hold_k%0d", k), {lock_timeout, locked, req_ready}, 6'b010000);
        end
        next_cycle(); @(negedge clk);
        check("t4_timeout_k16", {lock_timeout, locked, req_ready}, 6'b100001);
        next_cycle(); clear_reqs(); @(negedge clk);
        check("t4_pulse_end", {lock_timeout, locked}, 2'b00);
        next_cycle(); @(negedge clk);
        check("t4_req0_rsp", rsp_valid, 4'b0001);
        check("t4_req0_data", rsp_data, ram_default(8'h51));

        // Write then read the same address back-to-back
        do_reset();
        next_cycle(); set_req(0, 1'b1, 1'b1, 1'b0, 8'h10, 32'hDEAD_BEEF);
        @(negedge clk); check("t5_wr_ready", req_ready, 4'b0001);
        next_cycle(); set_req(0, 1'b1, 1'b0, 1'b0, 8'h10, '0);
        @(negedge clk);
        check("t5_rd_ready", req_ready, 4'b0001);
        check("t5_wr_port", {mem_we, mem_addr, mem_wdata}, {1'b1, 8'h10, 32'hDEAD_BEEF});
        next_cycle(); clear_reqs(); @(negedge clk);
        check("t5_rd_port", {mem_we, mem_addr, rsp_valid}, {1'b0, 8'h10, 4'b0000});
        next_cycle(); @(negedge clk);
        check("t5_rsp_valid", rsp_valid, 4'b0001);
        check("t5_rsp_data", rsp_data, 32'hDEAD_BEEF);

        // Reset one cycle after a read is accepted
        do_reset();
        next_cycle(); set_req(2, 1'b1, 1'b0, 1'b0, 8'h05, '0);
        @(negedge clk); check("t6_ready", req_ready, 4'b0100);
        next_cycle(); clear_reqs(); rst_n = 1'b0;
        @(negedge clk);
        check("t6_in_reset", {rsp_valid, mem_addr}, '0);
        next_cycle(); rst_n = 1'b1;
        @(negedge clk);
        check("t6_after_ctrl", {req_ready, rsp_valid, mem_we, locked, lock_timeout, lock_owner, mem_addr}, '0);
        check("t6_after_data", {mem_wdata, rsp_data}, '0);
        next_cycle();
        set_req(1, 1'b1, 1'b0, 1'b0, 8'h61, '0);
        set_req(3, 1'b1, 1'b0, 1'b0, 8'h63, '0);
        @(negedge clk);
        check("t6_first_grant", req_ready, 4'b0010);
        check("t6_no_stale_rsp", rsp_valid, 4'b0000);
        next_cycle(); clear_reqs(); @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
